// File: rtl/tree_pipe_pkg.sv
// Shared constants and helpers for the random-forest tree-traversal pipeline.
package tree_pipe_pkg;

  localparam int SAMPLE_W    = 256;
  localparam int MAX_DEPTH   = 16;
  localparam int STALL_CNT_W = 16;

  // Width of the node index after a stage optionally appends its branch bit.
  function automatic int next_idx_w(input int w, input int ext);
    return w + ext;
  endfunction

endpackage

// File: rtl/tree_stage_slot.sv
// One storage slot of the tree-stage skid register: valid bit, sample vector and formed index.
module tree_stage_slot #(
  parameter int DATA_W = 256,
  parameter int IDX_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] sample_d,
  input  logic [IDX_W-1:0]  idx_d,
  output logic              valid,
  output logic [DATA_W-1:0] sample_q,
  output logic [IDX_W-1:0]  idx_q
);

  // Load wins over clear so a slot can be refilled in the cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      sample_q <= '0;
      idx_q    <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      sample_q <= sample_d;
      idx_q    <= idx_d;
    end else if (clear) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/tree_stage_skid_reg.sv
// Elastic two-entry skid register between tree node-evaluation stages.
// Optional stall-cycle counter port enabled by TREE_STAGE_PERF_EN.
module tree_stage_skid_reg
  import tree_pipe_pkg::*;
#(
  parameter  int DATA_W    = SAMPLE_W,
  parameter  int IDX_W     = 1,
  parameter  int EXTEND    = 0,
  localparam int OUT_IDX_W = next_idx_w(IDX_W, EXTEND)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      sample_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic                   branch_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      sample_o,
  output logic [OUT_IDX_W-1:0]   idx_o
`ifdef TREE_STAGE_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  logic [OUT_IDX_W-1:0] in_idx;
  logic                 main_valid, skid_valid;
  logic [DATA_W-1:0]    skid_sample, main_sample_d;
  logic [OUT_IDX_W-1:0] skid_idx, main_idx_d;
  logic                 accept, drain;
  logic                 main_load, main_clear, main_from_skid;
  logic                 skid_load, skid_clear;

  // The branch bit becomes the new LSB, pushing the parent index up a level.
  generate
    if (EXTEND != 0) begin : g_extend
      assign in_idx = {idx_i, branch_i};
    end else begin : g_pass
      logic unused_branch;
      assign in_idx        = idx_i;
      assign unused_branch = branch_i;
    end
  endgenerate

  assign in_ready_o  = !skid_valid;
  assign out_valid_o = main_valid;
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = main_valid & out_ready_i;

  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush_i) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        skid_load      = accept;
        skid_clear     = !accept;
      end else begin
        main_load  = accept;
        main_clear = !accept;
      end
    end else begin
      skid_load = accept;
    end
  end

  assign main_sample_d = main_from_skid ? skid_sample : sample_i;
  assign main_idx_d    = main_from_skid ? skid_idx    : in_idx;

  tree_stage_slot #(.DATA_W(DATA_W), .IDX_W(OUT_IDX_W)) u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (main_load),
    .clear    (main_clear),
    .sample_d (main_sample_d),
    .idx_d    (main_idx_d),
    .valid    (main_valid),
    .sample_q (sample_o),
    .idx_q    (idx_o)
  );

  tree_stage_slot #(.DATA_W(DATA_W), .IDX_W(OUT_IDX_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .sample_d (sample_i),
    .idx_d    (in_idx),
    .valid    (skid_valid),
    .sample_q (skid_sample),
    .idx_q    (skid_idx)
  );

`ifdef TREE_STAGE_PERF_EN
  // Counts cycles a valid output is held off by downstream; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (main_valid && !out_ready_i && (stall_cnt_o != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tree_stage_skid_reg.sv
// Randomised and directed check of tree_stage_skid_reg against a FIFO-queue reference model.
module tb_tree_stage_skid_reg;

  typedef struct {
    logic [255:0] s;
    logic [3:0]   i3;
    logic [7:0]   i8;
  } entry_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic [255:0] sample_i = '0;
  logic [2:0]   idx3_i = '0;
  logic [7:0]   idx8_i = '0;
  logic         branch_i = 1'b0;
  logic         out_ready_i = 1'b0;

  logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [255:0] sample_a, sample_b;
  logic [3:0]   idx_a;
  logic [7:0]   idx_b;
`ifdef TREE_STAGE_PERF_EN
  logic [15:0]  stall_a, stall_b;
`endif

  int     total = 0;
  int     bad = 0;
  entry_t q[$];
  int     stall_model = 0;

  always #5 clk = ~clk;

  tree_stage_skid_reg #(.DATA_W(256), .IDX_W(3), .EXTEND(1)) dut_ext (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_a),
    .sample_i    (sample_i),
    .idx_i       (idx3_i),
    .branch_i    (branch_i),
    .out_valid_o (out_valid_a),
    .out_ready_i (out_ready_i),
    .sample_o    (sample_a),
    .idx_o       (idx_a)
`ifdef TREE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_a)
`endif
  );

  tree_stage_skid_reg #(.DATA_W(256), .IDX_W(8), .EXTEND(0)) dut_pass (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_b),
    .sample_i    (sample_i),
    .idx_i       (idx8_i),
    .branch_i    (branch_i),
    .out_valid_o (out_valid_b),
    .out_ready_i (out_ready_i),
    .sample_o    (sample_b),
    .idx_o       (idx_b)
`ifdef TREE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_b)
`endif
  );

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The model holds up to two entries; ready means room for another.
  task automatic compareModel();
    checkOutput("out_valid_a", 256'(out_valid_a), 256'(q.size() > 0));
    checkOutput("in_ready_a",  256'(in_ready_a),  256'(q.size() < 2));
    checkOutput("out_valid_b", 256'(out_valid_b), 256'(q.size() > 0));
    checkOutput("in_ready_b",  256'(in_ready_b),  256'(q.size() < 2));
    if (q.size() > 0) begin
      checkOutput("sample_a", sample_a, q[0].s);
      checkOutput("idx_a",    256'(idx_a), 256'(q[0].i3));
      checkOutput("sample_b", sample_b, q[0].s);
      checkOutput("idx_b",    256'(idx_b), 256'(q[0].i8));
    end
`ifdef TREE_STAGE_PERF_EN
    checkOutput("stall_a", 256'(stall_a), 256'(stall_model));
`endif
  endtask

  task automatic applyStimulus(input logic v, input logic [255:0] s, input logic [2:0] i3,
                               input logic br, input logic [7:0] i8, input logic rdy,
                               input logic fl);
    entry_t e;
    bit     room;
    @(negedge clk);
    compareModel();
    in_valid_i  = v;
    sample_i    = s;
    idx3_i      = i3;
    branch_i    = br;
    idx8_i      = i8;
    out_ready_i = rdy;
    flush_i     = fl;
    if (q.size() > 0 && !rdy && stall_model < 65535) stall_model++;
    if (fl) begin
      q.delete();
    end else begin
      room = (q.size() < 2);
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (v && room) begin
        e.s  = s;
        e.i3 = {i3, br};
        e.i8 = i8;
        q.push_back(e);
      end
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [255:0] sa, sb, sc;

  initial begin
    #1;
    checkOutput("rst_out_valid", 256'(out_valid_a), 256'(0));
    checkOutput("rst_in_ready",  256'(in_ready_a),  256'(1));
    checkOutput("rst_sample",    sample_a,          256'(0));
    checkOutput("rst_idx",       256'(idx_a),       256'(0));
`ifdef TREE_STAGE_PERF_EN
    checkOutput("rst_stall",     256'(stall_a),     256'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming with branch-bit extension.
    sa = rnd256();
    sb = rnd256();
    applyStimulus(1'b1, sa, 3'b101, 1'b1, 8'h11, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("stream_idx0",   256'(idx_a),      256'(4'b1011));
    checkOutput("stream_valid0", 256'(out_valid_a), 256'(1));
    checkOutput("stream_ready0", 256'(in_ready_a),  256'(1));
    applyStimulus(1'b1, sb, 3'b010, 1'b0, 8'h22, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("stream_idx1",   256'(idx_a),      256'(4'b0100));
    checkOutput("stream_ready1", 256'(in_ready_a),  256'(1));
    applyStimulus(1'b0, '0, 3'd0, 1'b0, 8'h0, 1'b1, 1'b0);

    // Back-pressure: A held, B in skid, C refused until space opens.
    sa = rnd256();
    sb = rnd256();
    sc = rnd256();
    applyStimulus(1'b1, sa, 3'd1, 1'b0, 8'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, sb, 3'd2, 1'b1, 8'hB0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("bp_ready_low", 256'(in_ready_a), 256'(0));
    checkOutput("bp_hold_A",    sample_a,         sa);
    applyStimulus(1'b1, sc, 3'd3, 1'b0, 8'hC0, 1'b0, 1'b0);
    applyStimulus(1'b1, sc, 3'd3, 1'b0, 8'hC0, 1'b1, 1'b0);
    applyStimulus(1'b1, sc, 3'd3, 1'b0, 8'hC0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 3'd0, 1'b0, 8'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 3'd0, 1'b0, 8'h0, 1'b1, 1'b0);

    // Flush with both slots full and a concurrent input.
    applyStimulus(1'b1, rnd256(), 3'd4, 1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, rnd256(), 3'd5, 1'b0, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, rnd256(), 3'd6, 1'b1, 8'h03, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("flush_valid", 256'(out_valid_a), 256'(0));
    checkOutput("flush_ready", 256'(in_ready_a),  256'(1));
    applyStimulus(1'b0, '0, 3'd0, 1'b0, 8'h0, 1'b1, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), rnd256(), 3'($urandom), 1'($urandom),
                    8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset while both slots hold entries.
    applyStimulus(1'b1, rnd256(), 3'd7, 1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus(1'b1, rnd256(), 3'd1, 1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b1, rnd256(), 3'd2, 1'b1, 8'h66, 1'b0, 1'b0);
    @(negedge clk);
    compareModel();
    in_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid",  256'(out_valid_a), 256'(0));
    checkOutput("arst_ready",  256'(in_ready_a),  256'(1));
    checkOutput("arst_sample", sample_a,          256'(0));
    checkOutput("arst_idx",    256'(idx_a),       256'(0));
    q.delete();
    stall_model = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through index ignores the branch bit.
    applyStimulus(1'b1, rnd256(), 3'd0, 1'b1, 8'hA5, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("pass_idx0", 256'(idx_b), 256'(8'hA5));
    applyStimulus(1'b0, '0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("pass_idx1", 256'(idx_b), 256'(8'hA5));

`ifdef TREE_STAGE_PERF_EN
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b0, '0, 3'd0, 1'($urandom), 8'h00, 1'b0, 1'b0);
    end
    @(negedge clk);
    checkOutput("stall_sat", 256'(stall_a), 256'(16'hFFFF));
    applyStimulus(1'b0, '0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("stall_flush", 256'(stall_a), 256'(16'hFFFF));
`endif

    applyStimulus(1'b0, '0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    compareModel();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
